// File: rtl/exp_approx.sv
// Fixed-point e^x approximation: x*log2(e) splits into an integer exponent k and a
// fraction f, 2^f comes from a quadratic, and the result is scaled by 2^k with saturation.
module exp_approx #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] x,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] y
);

    localparam int TW = 2*WIDTH - FRAC;
    localparam int KW = TW - FRAC;
    localparam int SW = $clog2(WIDTH);

    localparam longint LOG2E_I = ((longint'(14426950) << FRAC) + longint'(5000000)) / longint'(10000000);
    localparam longint C1_I    = ((longint'(21) << FRAC) + longint'(16)) / longint'(32);
    localparam longint C2_I    = ((longint'(11) << FRAC) + longint'(16)) / longint'(32);

    localparam logic signed [2*WIDTH-1:0] LOG2E = (2*WIDTH)'(LOG2E_I);
    localparam logic [2*FRAC-1:0]         C1    = (2*FRAC)'(C1_I);
    localparam logic [2*FRAC-1:0]         C2    = (2*FRAC)'(C2_I);
    localparam logic signed [KW-1:0]      K_SAT = KW'(WIDTH - 1 - FRAC);
    localparam logic signed [KW-1:0]      K_UNF = KW'(-(FRAC + 1));
    localparam logic [WIDTH-1:0]          Y_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    // 2^f for f in [0,1): 1 + C1*f + C2*f^2, every product truncated
    function automatic logic [FRAC:0] poly(input logic [FRAC-1:0] f);
        logic [2*FRAC-1:0] fw;
        logic [2*FRAC-1:0] lin;
        logic [2*FRAC-1:0] sq;
        logic [2*FRAC-1:0] quad;
        fw   = (2*FRAC)'(f);
        lin  = (fw * C1) >> FRAC;
        sq   = (fw * fw) >> FRAC;
        quad = (sq * C2) >> FRAC;
        poly = (FRAC+1)'((2*FRAC)'(1 << FRAC) + lin + quad);
    endfunction

    // p is always in [2^FRAC, 2^(FRAC+1)), so the overflow/underflow points depend on k alone
    function automatic logic [WIDTH-1:0] scale(input logic signed [KW-1:0] k,
                                               input logic [FRAC:0] p);
        logic [WIDTH-1:0] pw;
        pw = WIDTH'(p);
        if (k >= K_SAT)
            scale = Y_MAX;
        else if (k <= K_UNF)
            scale = '0;
        else if (!k[KW-1])
            scale = pw << SW'(k);
        else
            scale = pw >> SW'(-k);
    endfunction

    logic signed [2*WIDTH-1:0] x_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [TW-1:0]      t_p0;
    logic signed [KW-1:0]      k_p1;
    logic [FRAC-1:0]           f_p1;
    logic signed [KW-1:0]      k_p2;
    logic [FRAC:0]             p_p2;
    logic                      vld_p0;
    logic                      vld_p1;
    logic                      vld_p2;

    always_comb begin
        x_ext = {{WIDTH{x[WIDTH-1]}}, x};
        prod  = x_ext * LOG2E;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
        end else begin
            vld_p0    <= in_valid;
            vld_p1    <= vld_p0;
            vld_p2    <= vld_p1;
            out_valid <= vld_p2;
            if (vld_p2)
                y <= scale(k_p2, p_p2);
        end
    end

    always_ff @(posedge clk) begin
        // p0: t = floor(x * log2(e))
        t_p0 <= TW'(prod >>> FRAC);
        // p1: integer / fraction split
        k_p1 <= KW'(t_p0 >>> FRAC);
        f_p1 <= t_p0[FRAC-1:0];
        // p2: fractional power of two
        k_p2 <= k_p1;
        p_p2 <= poly(f_p1);
    end

endmodule

// File: tb/tb_exp_approx.sv
// Bench for exp_approx: vector table and random stream checked through an in-order
// scoreboard, plus hand-written latency and mid-stream reset sequences.
module tb_exp_approx;

    localparam int WIDTH = 16;
    localparam int FRAC  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic signed [WIDTH-1:0] x;
    logic                    out_valid;
    logic signed [WIDTH-1:0] y;

    always #5 clk = ~clk;

    exp_approx #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x),
        .out_valid(out_valid), .y(y)
    );

    typedef struct { int x_in; int exp_y; string name; } vec_t;
    typedef struct { int y; string name; } exp_t;

    vec_t tbl[15];
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   last_y  = 0;
    bit   mon_en  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: floor divisions and powers of two in plain integer arithmetic
    function automatic int model(input int xi);
        longint prod, t, k, f, p;
        prod = longint'(xi) * 369;
        t = prod / 256;
        if ((prod % 256 != 0) && (prod < 0)) t = t - 1;
        k = t / 256;
        if ((t % 256 != 0) && (t < 0)) k = k - 1;
        f = t - k * 256;
        p = 256 + (f * 168) / 256 + (((f * f) / 256) * 88) / 256;
        if (k >= 7) return 32767;
        if (k <= -9) return 0;
        if (k >= 0) return int'(p * (longint'(1) << k));
        return int'(p / (longint'(1) << (-k)));
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check(e.name, int'(y), e.y);
                    last_y = e.y;
                end
            end else begin
                check("y_hold", int'(y), last_y);
            end
        end
    end

    task automatic drive(input int xv, input string name, input int ey);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        x = 16'(xv);
        e.y = ey;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic idle_and_drain();
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        check("drain_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        tbl[0]  = '{0,      256,   "x_zero"};
        tbl[1]  = '{-307,   76,    "x_m1p2"};
        tbl[2]  = '{256,    692,   "x_one"};
        tbl[3]  = '{32767,  32767, "x_max_sat"};
        tbl[4]  = '{-32768, 0,     "x_min_zero"};
        tbl[5]  = '{1280,   32767, "x_five_sat"};
        tbl[6]  = '{-256,   94,    "x_m_one"};
        tbl[7]  = '{512,    1888,  "x_two"};
        tbl[8]  = '{1242,   32512, "k6_f254"};
        tbl[9]  = '{1243,   32640, "k6_f255"};
        tbl[10] = '{1244,   32767, "k7_sat_edge"};
        tbl[11] = '{-1420,  1,     "k_m8_edge"};
        tbl[12] = '{-1421,  0,     "k_m9_zero"};
        tbl[13] = '{1,      256,   "x_one_lsb"};
        tbl[14] = '{-1,     254,   "x_m_one_lsb"};

        rst = 1'b1;
        in_valid = 1'b0;
        x = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_y", int'(y), 0);

        // single pulse: result visible only after the third edge
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b1; x = '0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk); check("lat_n0_valid", int'(out_valid), 0);
        @(negedge clk); check("lat_n1_valid", int'(out_valid), 0);
        @(negedge clk); check("lat_n2_valid", int'(out_valid), 0);
        @(negedge clk); check("lat_n3_valid", int'(out_valid), 1);
                        check("lat_n3_y", int'(y), 256);
        @(negedge clk); check("lat_n4_valid", int'(out_valid), 0);
                        check("lat_n4_y_hold", int'(y), 256);
        last_y = 256;
        mon_en = 1'b1;

        // back-to-back vector table
        for (int i = 0; i < 15; i++) drive(tbl[i].x_in, tbl[i].name, tbl[i].exp_y);
        idle_and_drain();

        // random stream with gaps, mixing mid-range and full-range arguments
        for (int i = 0; i < 60; i++) begin
            int xv;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1 in_valid = 1'b0;
            end else begin
                if ($urandom_range(0, 1) == 1) xv = int'($urandom_range(0, 4000)) - 2400;
                else xv = int'($signed(16'($urandom())));
                drive(xv, "random_y", model(xv));
            end
        end
        idle_and_drain();

        // reset in the middle of a stream discards everything in flight
        mon_en = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b1; x = 16'(100);
        @(posedge clk);
        #1 x = 16'(200);
        @(posedge clk);
        #1 x = 16'(300); rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; x = 16'(256);
        @(negedge clk); check("rst_mid_valid", int'(out_valid), 0);
                        check("rst_mid_y", int'(y), 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk); check("rst_stale_1", int'(out_valid), 0);
        @(negedge clk); check("rst_stale_2", int'(out_valid), 0);
        @(negedge clk); check("rst_stale_3", int'(out_valid), 0);
                        check("rst_stale_y", int'(y), 0);
        @(negedge clk); check("post_rst_valid", int'(out_valid), 1);
                        check("post_rst_y", int'(y), 692);
        @(negedge clk); check("post_rst_pulse_end", int'(out_valid), 0);
                        check("post_rst_y_hold", int'(y), 692);
        last_y = 692;
        mon_en = 1'b1;
        repeat (4) @(posedge clk);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
